aos_read_packet_buffer: RTL and testbench

//  Per-app elastic buffer feeding the PCIS read-packet stage. Each app pushes

---
 rtl/aos_read_packet_buffer_pkg.sv | 23 ++
 rtl/aos_packet_fifo.sv | 55 +++++
 rtl/aos_read_packet_buffer.sv | 85 ++++++++
 tb/tb_aos_read_packet_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/aos_read_packet_buffer_pkg.sv
// Shared types for the AOS read-packet buffer: packet beat layout, app indexing and FIFO sizing.
package aos_read_packet_buffer_pkg;

  localparam int AMI_APP_BITS    = 3;
  localparam int AMI_NUM_APPS    = 4;
  localparam int AOS_SLOT_BITS   = 4;
  localparam int AOS_RDBUF_DEPTH = 16;

  typedef logic [$clog2(AOS_RDBUF_DEPTH+1)-1:0] aos_rdbuf_level_t;

  typedef struct packed {
    logic                     valid;
    logic [511:0]             data;
    logic [AOS_SLOT_BITS-1:0] slot;
  } AOSPacket;

  // What a FIFO entry actually stores; valid is implied by occupancy.
  typedef struct packed {
    logic [511:0]             data;
    logic [AOS_SLOT_BITS-1:0] slot;
  } aos_payload_t;

endpackage

// File: rtl/aos_packet_fifo.sv
// Single-clock FIFO of packet payloads; full/empty from extra-MSB pointers, level kept as a register.
module aos_packet_fifo
  import aos_read_packet_buffer_pkg::*;
#(
  parameter  int FIFO_DEPTH = AOS_RDBUF_DEPTH,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int LEVEL_W    = $clog2(FIFO_DEPTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  aos_payload_t       din,
  output aos_payload_t       dout,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  aos_payload_t     mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is never reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[PTR_W-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/aos_read_packet_buffer.sv
// Per-app elastic buffer in front of the PCIS read-packet stage: one FIFO per app, head selected by app number.
// Optional AOS_RDBUF_STATS_EN adds saturating per-app pop and stall counters.
module aos_read_packet_buffer
  import aos_read_packet_buffer_pkg::*;
#(
  parameter  int NUM_APPS   = AMI_NUM_APPS,
  parameter  int FIFO_DEPTH = AOS_RDBUF_DEPTH,
  localparam int LEVEL_W    = $clog2(FIFO_DEPTH+1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  AOSPacket                    app_pkt_in [NUM_APPS],
  output logic [NUM_APPS-1:0]         app_pkt_in_ready,
  output AOSPacket                    pkt_out,
  input  logic                        pkt_out_ready,
  input  logic [AMI_APP_BITS-1:0]     pkt_out_app,
  output logic [NUM_APPS*LEVEL_W-1:0] fifo_level
`ifdef AOS_RDBUF_STATS_EN
  ,
  output logic [31:0]                 stat_beats [NUM_APPS],
  output logic [31:0]                 stat_stall [NUM_APPS]
`endif
);

  aos_payload_t       head  [NUM_APPS];
  logic [LEVEL_W-1:0] level [NUM_APPS];
  logic [NUM_APPS-1:0] full;
  logic [NUM_APPS-1:0] empty;
  logic [NUM_APPS-1:0] push;
  logic [NUM_APPS-1:0] pop;

  for (genvar g = 0; g < NUM_APPS; g++) begin : g_app
    assign push[g] = app_pkt_in[g].valid;
    assign pop[g]  = pkt_out_ready && !empty[g] && (pkt_out_app == AMI_APP_BITS'(g));
    assign app_pkt_in_ready[g] = !full[g];
    assign fifo_level[g*LEVEL_W +: LEVEL_W] = level[g];

    aos_packet_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   ('{data: app_pkt_in[g].data, slot: app_pkt_in[g].slot}),
      .dout  (head[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .level (level[g])
    );
  end

  // Out-of-range selections fall through with the all-zero default.
  always_comb begin
    pkt_out = '0;
    for (int i = 0; i < NUM_APPS; i++) begin
      if (pkt_out_app == AMI_APP_BITS'(i)) begin
        pkt_out.valid = !empty[i];
        pkt_out.data  = head[i].data;
        pkt_out.slot  = head[i].slot;
      end
    end
  end

`ifdef AOS_RDBUF_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_APPS; i++) begin
        stat_beats[i] <= '0;
        stat_stall[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_APPS; i++) begin
        if (pop[i]) stat_beats[i] <= sat_inc(stat_beats[i]);
        if (push[i] && full[i]) stat_stall[i] <= sat_inc(stat_stall[i]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_aos_read_packet_buffer.sv
// Scoreboard bench for aos_read_packet_buffer: directed scenarios plus a randomized phase against per-app queues.
module tb_aos_read_packet_buffer;
  import aos_read_packet_buffer_pkg::*;

  localparam int NA = AMI_NUM_APPS;
  localparam int D  = AOS_RDBUF_DEPTH;
  localparam int LW = $clog2(D+1);
  localparam int PW = 512 + AOS_SLOT_BITS;

  logic                    clk;
  logic                    rst;
  AOSPacket                app_in [NA];
  logic [NA-1:0]           app_ready;
  AOSPacket                pkt_out;
  logic                    pkt_ready;
  logic [AMI_APP_BITS-1:0] sel;
  logic [NA*LW-1:0]        fifo_level;
`ifdef AOS_RDBUF_STATS_EN
  logic [31:0]             stat_beats [NA];
  logic [31:0]             stat_stall [NA];
`endif

  logic [NA-1:0]              app_vld;
  logic [511:0]               app_dat [NA];
  logic [AOS_SLOT_BITS-1:0]   app_slt [NA];
  logic [NA-1:0]              last_acc;
  bit                         auto_data;

  for (genvar g = 0; g < NA; g++) begin : g_drv
    assign app_in[g] = '{valid: app_vld[g], data: app_dat[g], slot: app_slt[g]};
  end

  aos_read_packet_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .app_pkt_in       (app_in),
    .app_pkt_in_ready (app_ready),
    .pkt_out          (pkt_out),
    .pkt_out_ready    (pkt_ready),
    .pkt_out_app      (sel),
    .fifo_level       (fifo_level)
`ifdef AOS_RDBUF_STATS_EN
    ,
    .stat_beats       (stat_beats),
    .stat_stall       (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue of {data,slot} per app, plus counters.
  logic [PW-1:0] q [NA][$];
  int unsigned   m_beats [NA];
  int unsigned   m_stall [NA];
  int            checks = 0;
  int            errors = 0;
  bit            armed  = 0;

  task automatic chk(input string nm, input int app, input logic [575:0] act, input logic [575:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s app=%0d t=%0t actual=%0h required=%0h", nm, app, $time, act, exp);
    end
  endtask

  // Monitor: compare visible outputs with the model, then advance the model with this cycle's handshakes.
  always @(negedge clk) begin
    int  s;
    bit  exp_v;
    bit  take_pop;
    bit  take_push [NA];
    s = int'(sel);
    exp_v = (s < NA) && (q[s].size() > 0);
    if (armed) begin
      for (int i = 0; i < NA; i++) begin
        chk("ready", i, 576'(app_ready[i]), 576'(q[i].size() < D));
        chk("level", i, 576'(fifo_level[i*LW +: LW]), 576'(q[i].size()));
`ifdef AOS_RDBUF_STATS_EN
        chk("stat_beats", i, 576'(stat_beats[i]), 576'(m_beats[i]));
        chk("stat_stall", i, 576'(stat_stall[i]), 576'(m_stall[i]));
`endif
      end
      chk("valid", s, 576'(pkt_out.valid), 576'(exp_v));
      if (exp_v)
        chk("head", s, 576'({pkt_out.data, pkt_out.slot}), 576'(q[s][0]));
      else if (s >= NA)
        chk("oor_data", s, 576'({pkt_out.data, pkt_out.slot}), 576'(0));
    end
    if (rst) begin
      for (int i = 0; i < NA; i++) begin
        q[i].delete();
        m_beats[i] = 0;
        m_stall[i] = 0;
      end
      armed = 1;
    end else if (armed) begin
      take_pop = exp_v && pkt_ready;
      for (int i = 0; i < NA; i++) begin
        take_push[i] = app_vld[i] && (q[i].size() < D);
        if (app_vld[i] && q[i].size() == D && m_stall[i] != 32'hFFFF_FFFF) m_stall[i]++;
      end
      if (take_pop) begin
        void'(q[s].pop_front());
        if (m_beats[s] != 32'hFFFF_FFFF) m_beats[s]++;
      end
      for (int i = 0; i < NA; i++)
        if (take_push[i]) q[i].push_back({app_dat[i], app_slt[i]});
    end
  end

  task automatic new_beat(input int i);
    app_dat[i] = {16{$urandom()}};
    app_slt[i] = AOS_SLOT_BITS'($urandom_range(0, (1 << AOS_SLOT_BITS) - 1));
  endtask

  // One clock; an accepted beat is replaced with fresh random data, an unaccepted one is held.
  task automatic tick();
    @(negedge clk);
    last_acc = app_vld & app_ready;
    @(posedge clk);
    #1;
    if (auto_data)
      for (int i = 0; i < NA; i++) if (last_acc[i]) new_beat(i);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic drain();
    app_vld   = '0;
    pkt_ready = 1'b1;
    for (int a = 0; a < NA; a++) begin
      sel = AMI_APP_BITS'(a);
      ticks(D + 2);
    end
    pkt_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    app_vld   = '0;
    pkt_ready = 1'b0;
    sel       = '0;
    auto_data = 1'b0;
    last_acc  = '0;
    for (int i = 0; i < NA; i++) begin
      app_dat[i] = '0;
      app_slt[i] = '0;
    end
    ticks(3);
    rst = 1'b0;
    tick();

    // Three known beats into app 2, then read them back-to-back.
    app_vld[2] = 1'b1;
    app_dat[2] = 512'hA; app_slt[2] = 4'd1; tick();
    app_dat[2] = 512'hB; app_slt[2] = 4'd2; tick();
    app_dat[2] = 512'hC; app_slt[2] = 4'd3; tick();
    app_vld[2] = 1'b0;
    sel = 3'd2;
    pkt_ready = 1'b1;
    ticks(5);
    pkt_ready = 1'b0;

    // Fill app 0 past capacity, release one slot, then drain in order.
    auto_data = 1'b1;
    for (int i = 0; i < NA; i++) new_beat(i);
    sel = 3'd0;
    app_vld[0] = 1'b1;
    ticks(D + 4);
    pkt_ready = 1'b1; tick();
    pkt_ready = 1'b0; ticks(3);
    drain();

    // Apps 1 and 3 interleaved on the read side.
    app_vld[1] = 1'b1; app_vld[3] = 1'b1;
    ticks(4);
    app_vld = '0;
    pkt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sel = (k % 2 == 0) ? 3'd1 : 3'd3;
      tick();
    end
    pkt_ready = 1'b0;

    // Steady-state push+pop on app 1 at level 5.
    app_vld[1] = 1'b1;
    ticks(5);
    sel = 3'd1;
    pkt_ready = 1'b1;
    ticks(100);
    drain();

    // Out-of-range selection with every FIFO holding data.
    app_vld = '1;
    tick();
    app_vld = '0;
    sel = 3'(NA);
    pkt_ready = 1'b1;
    ticks(3);
    drain();

    // Reset while app 0 holds 7 beats and a pop is in progress.
    app_vld[0] = 1'b1;
    ticks(7);
    app_vld = '0;
    sel = 3'd0;
    pkt_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pkt_ready = 1'b0;
    ticks(2);

    // Randomized traffic, including out-of-range selections.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NA; i++)
        if (!app_vld[i] || last_acc[i]) app_vld[i] = ($urandom_range(0, 99) < 60);
      sel = AMI_APP_BITS'($urandom_range(0, NA));
      pkt_ready = ($urandom_range(0, 99) < 45);
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
